// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the AES column-mixing engine.
// The slave modport is the engine's view; the master modport is the driver's view.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_inv,
    input  in_state,
    output out_valid,
    input  out_ready,
    output out_state
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_inv,
    output in_state,
    input  out_valid,
    output out_ready,
    input  out_state
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns per BUSY cycle in place.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mix_columns_seq_if.slave bus
);

  localparam int N_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] d [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      d[i] = xt(a[i]);
    end
    return {d[0] ^ d[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ d[1] ^ d[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ d[2] ^ d[3] ^ a[3],
            d[0] ^ a[0] ^ a[1] ^ a[2] ^ d[3]};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2[i]  = xt(a[i]);
      x4[i]  = xt(x2[i]);
      x8[i]  = xt(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  state_e            r_fsm;
  state_e            w_fsm_n;
  logic [0:3][31:0]  r_state;
  logic [0:3][31:0]  w_state_n;
  logic              r_inv;
  logic              w_inv_n;
  logic [1:0]        r_step;
  logic [1:0]        w_step_n;

  logic [1:0]  w_idx  [COLS_PER_CYCLE];
  logic [31:0] w_col  [COLS_PER_CYCLE];
  logic [31:0] w_fwd  [COLS_PER_CYCLE];
  logic [31:0] w_invc [COLS_PER_CYCLE];

  // One forward and one inverse unit per lane; the mode register picks.
  generate
    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
      assign w_idx[l]  = 2'(int'(r_step) * COLS_PER_CYCLE + l);
      assign w_col[l]  = r_state[w_idx[l]];
      assign w_fwd[l]  = mix_fwd(w_col[l]);
      assign w_invc[l] = mix_inv(w_col[l]);
    end
  endgenerate

  always_comb begin
    w_fsm_n   = r_fsm;
    w_state_n = r_state;
    w_inv_n   = r_inv;
    w_step_n  = r_step;
    unique case (r_fsm)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_n = bus.in_state;
          w_inv_n   = bus.in_inv;
          w_step_n  = 2'd0;
          w_fsm_n   = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
          w_state_n[w_idx[l]] = r_inv ? w_invc[l] : w_fwd[l];
        end
        w_step_n = r_step + 2'd1;
        if (r_step == LAST_STEP) w_fsm_n = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_fsm_n = S_IDLE;
      end
      default: w_fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_inv   <= 1'b0;
      r_step  <= 2'd0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_state <= w_state_n;
      r_inv   <= w_inv_n;
      r_step  <= w_step_n;
    end
  end

  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.out_valid = (r_fsm == S_DONE);
  assign bus.out_state = r_state;

endmodule
